// File: rtl/bidir_link_ctrl.sv
// Half-duplex controller for one shared bidirectional line: arbitrates local
// transmit bursts against remote receive strobes with high-Z turnaround gaps.
module bidir_link_ctrl #(
  parameter int WIDTH     = 1,
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] pad,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_strobe,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             drive_en,
  output logic             contention,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TC_W = (TURN_CYC  < 1) ? 1 : $clog2(TURN_CYC + 1);
  localparam int BC_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TC_W-1:0]   turn_q;
  logic [TC_W-1:0]   turn_ld_val;
  logic              turn_ld;
  logic              turn_dec;
  logic [BC_W-1:0]   beat_q;
  logic              beat_clr;
  logic              accept;
  logic              capture;
  logic              drive_d;
  logic [WIDTH-1:0]  drv_q;
  logic              mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign pad      = drive_en ? drv_q : {WIDTH{1'bz}};
  assign tx_ready = (state_q == TX);

  // Readback compare: X or Z on a line we are driving counts as contention.
  assign mismatch = drive_en && (pad !== drv_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    accept      = 1'b0;
    turn_ld     = 1'b0;
    turn_ld_val = '0;
    turn_dec    = 1'b0;
    beat_clr    = 1'b0;
    drive_d     = drive_en;
    case (state_q)
      RX: begin
        if (rx_strobe) begin
          capture = 1'b1;
        end else if (tx_valid) begin
          state_d     = TURN_TX;
          turn_ld     = 1'b1;
          turn_ld_val = TC_W'(TURN_CYC - 1);
        end
      end
      TURN_TX: begin
        if (rx_strobe) begin
          capture = 1'b1;
          state_d = RX;
        end else if (turn_q == '0) begin
          state_d  = TX;
          beat_clr = 1'b1;
        end else begin
          turn_dec = 1'b1;
        end
      end
      TX: begin
        if (tx_valid) begin
          accept  = 1'b1;
          drive_d = 1'b1;
          // Last beat stays on the line through the first TURN_RX cycle,
          // so that exit path needs one extra count to keep TURN_CYC idle cycles.
          if (beat_q == BC_W'(MAX_BURST - 1)) begin
            state_d     = TURN_RX;
            turn_ld     = 1'b1;
            turn_ld_val = TC_W'(TURN_CYC);
          end
        end else begin
          drive_d     = 1'b0;
          state_d     = TURN_RX;
          turn_ld     = 1'b1;
          turn_ld_val = TC_W'(TURN_CYC - 1);
        end
      end
      TURN_RX: begin
        drive_d = 1'b0;
        if (turn_q == '0) begin
          state_d = RX;
        end else begin
          turn_dec = 1'b1;
        end
      end
      default: begin
        state_d = RX;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_q   <= '0;
      beat_q   <= '0;
      drive_en <= 1'b0;
      drv_q    <= '0;
    end else begin
      if (turn_ld) begin
        turn_q <= turn_ld_val;
      end else if (turn_dec) begin
        turn_q <= turn_q - TC_W'(1);
      end
      if (beat_clr) begin
        beat_q <= '0;
      end else if (accept) begin
        beat_q <= beat_q + BC_W'(1);
      end
      if (accept) begin
        drv_q <= tx_data;
      end
      drive_en <= drive_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= capture;
      if (capture) begin
        rx_data <= pad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= 1'b0;
      err_cnt    <= '0;
    end else if (clr_err) begin
      contention <= 1'b0;
      err_cnt    <= '0;
    end else if (mismatch) begin
      contention <= 1'b1;
      err_cnt    <= sat_inc(err_cnt);
    end
  end

endmodule

// File: doc/bidir_link_ctrl.md
Name: bidir_link_ctrl

Overview:
- Half-duplex controller for one shared bidirectional line.
- Sits directly upstream of the tran-connected pass-through cell and drives its inout pin.
- Arbitrates local transmit bursts against remote receive strobes and inserts high-Z turnaround cycles so the two drivers never overlap.
- Reads the line back while driving and flags contention.

Parameters:
WIDTH, 1, bit width of the shared line and data paths
TURN_CYC, 2, released (high-Z) cycles inserted before and after each transmit burst; legal range >=1
MAX_BURST, 4, maximum beats accepted per burst; legal range >=1
CNT_W, 4, width of the saturating contention error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pad  inout  WIDTH  shared line; driven with drv_q when drive_en=1, otherwise 'z
tx_valid  input  1  local transmit request / beat valid
tx_data  input  WIDTH  transmit beat
tx_ready  output  1  beat accepted on an edge where tx_valid&tx_ready
rx_strobe  input  1  remote device has valid data on pad this cycle
rx_valid  output  1  one-cycle pulse: rx_data updated
rx_data  output  WIDTH  captured pad value
drive_en  output  1  registered; pad currently driven
contention  output  1  sticky: readback mismatch while driving
clr_err  input  1  synchronous clear of contention and err_cnt
err_cnt  output  CNT_W  saturating count of mismatch cycles

Behaviour:
- Reset: asynchronous, takes effect immediately on rst_n fall, including mid-burst.
  - state=RX, drive_en=0 (pad 'z immediately), drv_q=0, tx_ready=0.
  - rx_valid=0, rx_data=0, contention=0, err_cnt=0, turn counter=0, beat counter=0.
- tx_ready = (state==TX), decoded combinationally from state only.
- FSM:
  - RX: pad released.
    - rx_strobe=1: capture rx_data<=pad; rx_valid=1 the next cycle for exactly one cycle. rx_strobe has priority over tx_valid.
    - else tx_valid=1: go to TURN_TX, turn counter loaded.
  - TURN_TX: pad released; lasts exactly TURN_CYC cycles, then TX.
    - rx_strobe=1 in any TURN_TX cycle: abort to RX and capture as in RX (rx_valid next cycle). The pending tx request re-arbitrates from RX.
  - TX: beat counter cleared on entry.
    - tx_valid=1 on an edge: accept beat; drv_q<=tx_data, drive_en<=1, beat counter +1. The beat is driven on pad for exactly the following cycle.
    - On acceptance of beat MAX_BURST: go to TURN_RX.
    - tx_valid=0 on any TX edge (including the first TX cycle): go to TURN_RX, drive_en<=0, no beat accepted.
    - rx_strobe is ignored in TX.
  - TURN_RX:
    - drive_en<=0 at the first edge in TURN_RX. If entered on the MAX_BURST beat, the pad stays driven during the first TURN_RX cycle.
    - The state then waits TURN_CYC cycles with drive_en=0 before returning to RX.
    - rx_strobe and tx_valid are ignored.
- Contention check, every cycle with drive_en=1:
  - Condition: pad != drv_q. In simulation a 4-state compare (!==), so X/Z count as mismatch.
  - On mismatch: contention<=1; err_cnt increments, saturating at 2^CNT_W-1.
- clr_err=1: contention<=0, err_cnt<=0. Clear wins over a simultaneous mismatch.
- Guarantee: drive_en is never 1 in RX or TURN_TX. pad is released for at least TURN_CYC cycles between a local beat and any RX capture.
- rx_data holds its value between captures.

Test Plan:
1. RX capture: bench drives pad=1, rx_strobe pulse at cycle k -> rx_valid=1 and rx_data=1 at cycle k+1 only; pad never driven by block.
2. Burst of 3 (WIDTH=1, TURN_CYC=2, MAX_BURST=4), tx_valid rises at cycle 0, data 1,0,1, drops at cycle 6:
   - TURN_TX cycles 1-2; tx_ready=1 cycles 3-6.
   - pad=1,0,1 on cycles 4-6; pad 'z cycles 7-8.
   - RX at cycle 9; contention=0.
3. Burst limit: tx_valid held high 12 cycles -> exactly 4 beats driven; pad 'z for 2 cycles; RX for 1 cycle; then TURN_TX again.
4. Contention: bench forces pad=0 while block drives 1 for 20 cycles (CNT_W=4) -> contention=1, err_cnt saturates at 15; clr_err pulse -> both 0 next cycle.
5. Abort: rx_strobe asserted in second TURN_TX cycle with pad=1 -> RX next cycle, rx_valid=1, rx_data=1, drive_en stays 0, then re-enters TURN_TX.
6. Reset mid-burst: rst_n falls while pad driven -> pad 'z and all outputs 0 in the same timestep; after release, state RX.
